// File: rtl/pipe_pkg.sv
// Shared types and M->WB payload layout for the pipeline stage registers.
package pipe_pkg;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} pipe_state_t;
    typedef logic [1:0] pipe_occ_t;

    // M->WB payload: {wb_from_mem, wb_en, rd_addr[4:0], rd[31:0]}
    localparam int unsigned M_WB_PAYLOAD_W   = 39;
    localparam int unsigned M_WB_RD_LSB      = 0;
    localparam int unsigned M_WB_RD_W        = 32;
    localparam int unsigned M_WB_RD_ADDR_LSB = 32;
    localparam int unsigned M_WB_RD_ADDR_W   = 5;
    localparam int unsigned M_WB_WB_EN_BIT   = 37;
    localparam int unsigned M_WB_FROM_MEM_BIT = 38;

    // Bubble writes x0 only, so it is a harmless no-op in writeback.
    localparam logic [M_WB_PAYLOAD_W-1:0] M_WB_BUBBLE = 39'h20_0000_0000;

    function automatic pipe_occ_t occ_of(input pipe_state_t s);
        case (s)
            ST_ONE:  return 2'd1;
            ST_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Parametrised valid/ready pipeline stage with optional 2-entry skid buffer,
// synchronous flush, occupancy output and saturating stall counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned              PAYLOAD_W  = 39,
    parameter logic [PAYLOAD_W-1:0]     BUBBLE_VAL = PAYLOAD_W'(M_WB_BUBBLE),
    parameter bit                       SKID       = 1'b1,
    parameter int unsigned              CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output pipe_occ_t            occupancy,
    output logic [CNT_W-1:0]     stall_cycles
);

    pipe_state_t          state_q, state_d;
    logic [PAYLOAD_W-1:0] main_q, main_d;
    logic                 in_fire, out_fire;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign occupancy = occ_of(state_q);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    generate
        if (SKID) begin : g_skid
            logic [PAYLOAD_W-1:0] skid_q, skid_d;

            // Registered ready: only the skid-full state blocks upstream.
            assign in_ready = (state_q != ST_TWO);

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                if (flush) begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE_VAL;
                    skid_d  = BUBBLE_VAL;
                end else begin
                    case (state_q)
                        ST_EMPTY: begin
                            if (in_fire) begin
                                state_d = ST_ONE;
                                main_d  = in_data;
                            end
                        end
                        ST_ONE: begin
                            if (in_fire && out_fire) begin
                                main_d = in_data;
                            end else if (in_fire) begin
                                state_d = ST_TWO;
                                skid_d  = in_data;
                            end else if (out_fire) begin
                                state_d = ST_EMPTY;
                                main_d  = BUBBLE_VAL;
                            end
                        end
                        ST_TWO: begin
                            if (out_fire) begin
                                state_d = ST_ONE;
                                main_d  = skid_q;
                                skid_d  = BUBBLE_VAL;
                            end
                        end
                        default: begin
                            state_d = ST_EMPTY;
                            main_d  = BUBBLE_VAL;
                            skid_d  = BUBBLE_VAL;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    skid_q <= BUBBLE_VAL;
                end else begin
                    skid_q <= skid_d;
                end
            end
        end else begin : g_noskid
            assign in_ready = (state_q == ST_EMPTY) || out_ready;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                if (flush) begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE_VAL;
                end else if (in_fire) begin
                    state_d = ST_ONE;
                    main_d  = in_data;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE_VAL;
                end
            end
        end
    endgenerate

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (out_valid & ~out_ready),
        .count (stall_cycles)
    );

    // A flush kills upstream as well, so it may drop a pending offer.
    a_in_hold: assert property (@(posedge clk) disable iff (rst)
        (in_valid && !in_ready && !flush) |=> (in_valid && $stable(in_data)))
        else $error("in_valid/in_data retracted while stalled");

endmodule
